branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Instruction-side control unit that drives the program counter's steering interface (`pcsel`, `offset`, `address`, `clk_en`) from fetched Beta instruction words. It accepts one instruction at a time over a valid/ready handshake and classifies it as non-control or control (BEQ/BNE/JMP). For control instructions it reads `Ra` from the register file, writes the return address (PC+4) to `Rc`, and issues the redirect. It sits between instruction memory, the register file read/write ports, and the program counter.

## Interface

Parameters: none.

Ports:
- `clk` — in, 1 — system clock; all state updates on posedge.
- `rst` — in, 1 — reset; asynchronous, active-high.
- `instr_valid` — in, 1 — instruction word available.
- `instr_ready` — out, 1 — block can accept an instruction; equals (state==FETCH) and not `rst`.
- `instr` — in, 32 — Beta word: opcode[31:26], Rc[25:21], Ra[20:16], literal[15:0].
- `pc_next_i` — in, 32 — PC+4 from the program counter; sampled at accept.
- `ra_addr` — out, 5 — register file read address.
- `ra_data` — in, 32 — register file read data; valid one cycle after `ra_addr` is stable.
- `pc_clk_en` — out, 1 — one-cycle enable to the program counter.
- `pcsel` — out, 2 — 00 NORMAL, 01 BEQ, 10 JMP, 11 BNE.
- `offset` — out, 16 — raw literal. The program counter sign-extends it and multiplies by 4.
- `address` — out, 32 — Ra value. The PC tests it for zero (BEQ/BNE) or uses it as the jump target (JMP).
- `rc_we` — out, 1 — one-cycle register file write enable.
- `rc_addr` — out, 5 — write address.
- `rc_data` — out, 32 — write data (return address).
- `branch_count`, `taken_count` — out, 32 each — present only with `BRANCH_STATS_EN`.

## Operation

- **Opcodes:**
  - JMP = 6'h1B, BEQ = 6'h1C, BNE = 6'h1D.
  - All other opcodes are non-control.
- **FSM states:** FETCH, ADVANCE, READ, RESOLVE.
- **FETCH**
  - `instr_ready` = 1.
  - On `instr_valid`, latch `instr` and `pc_next_i`.
  - Control opcode: drive `ra_addr` = Ra and go to READ.
  - Otherwise: go to ADVANCE.
  - With `instr_valid` = 0: hold, all pulses 0.
- **ADVANCE**
  - `pc_clk_en` = 1, `pcsel` = 00, `rc_we` = 0.
  - Go to FETCH.
- **READ**
  - Hold `ra_addr`; `ra_data` becomes valid this cycle.
  - Register `address` from `ra_data`:
    - JMP: `address` = {ra_data[31:2], 2'b00}.
    - BEQ/BNE: `address` = `ra_data` unmodified.
  - Go to RESOLVE.
- **RESOLVE**
  - `pc_clk_en` = 1.
  - `pcsel` = 01/11/10 for BEQ/BNE/JMP; `offset` = literal.
  - `rc_addr` = Rc, `rc_data` = latched `pc_next_i`.
  - `rc_we` = 1 unless Rc == 31 (R31 is hardwired zero, write suppressed).
  - Go to FETCH.
- **Taken/not-taken:** this block does not resolve it; the program counter evaluates `address` against zero.
- **Outputs:** all registered. `pc_clk_en` and `rc_we` are single-cycle pulses. `pcsel`/`offset`/`address` hold their last values between pulses.
- **Reset** (asserted at any time, including mid-READ/RESOLVE):
  - State goes immediately to FETCH and the in-flight instruction is discarded.
  - All outputs are 0, including `instr_ready` while `rst` is high.
  - No pending `rc_we` or `pc_clk_en` is issued after release.

## Timing

- The instruction is accepted at posedge N (valid && ready).
- **Non-control:**
  - `pc_clk_en` is high during cycle N+1; the PC updates at posedge N+2.
  - `instr_ready` returns high in cycle N+2.
  - Throughput: 1 instruction per 2 cycles.
- **Control:**
  - READ in cycle N+1, RESOLVE outputs in cycle N+2, PC and `Rc` update at posedge N+3.
  - `instr_ready` is high again in cycle N+3.
  - Throughput: 1 per 3 cycles.
- `ra_addr` is stable from cycle N+1 through N+2.
- `instr` and `pc_next_i` are ignored outside the accept edge.

## Configuration

- Macro: `BRANCH_STATS_EN`.
- **Defined:**
  - Adds `branch_count` and `taken_count`, both reset to 0.
  - `branch_count` increments at the READ→RESOLVE edge for every control instruction.
  - `taken_count` increments at the same edge when taken: JMP always, BEQ when `ra_data` == 0, BNE when `ra_data` != 0.
  - Both counters saturate at 32'hFFFFFFFF.
- **Undefined:** ports and logic are absent; behaviour is otherwise identical.

## Test plan

- **Reset mid-operation:** assert `rst` during RESOLVE → `pc_clk_en` = 0, `rc_we` = 0, all outputs 0; after release `instr_ready` = 1 with no stray pulse.
- **Non-control:** accept `instr` = 32'h80000000 → one `pc_clk_en` pulse at N+1, `pcsel` = 00, `rc_we` = 0, `instr_ready` high at N+2.
- **BEQ:** `instr` = 32'h70A3FFFE, `ra_data` = 0, `pc_next_i` = 32'h104 → at N+2:
  - `ra_addr` = 3, `pcsel` = 01, `offset` = 16'hFFFE, `address` = 0;
  - `rc_we` = 1, `rc_addr` = 5, `rc_data` = 32'h104.
- **JMP:** `instr` = 32'h6C220000, `ra_data` = 32'h00001237 → `pcsel` = 10, `address` = 32'h00001234, `rc_addr` = 1.
- **BNE with Rc=31:** `instr` = 32'h77E40010 → `pcsel` = 11, `rc_we` stays 0 for all cycles.
- **`BRANCH_STATS_EN`:** BEQ with `ra_data` = 7, BNE with `ra_data` = 7, then JMP → `branch_count` = 3, `taken_count` = 2.

Source files
------------

// File: rtl/branch_ctrl.sv
// Beta branch/jump control: classifies fetched instructions and steers the PC and Rc write-back.
// Optional BRANCH_STATS_EN adds saturating branch_count/taken_count statistics.
module branch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc_next_i,
    output logic [4:0]  ra_addr,
    input  logic [31:0] ra_data,
    output logic        pc_clk_en,
    output logic [1:0]  pcsel,
    output logic [15:0] offset,
    output logic [31:0] address,
    output logic        rc_we,
    output logic [4:0]  rc_addr,
    output logic [31:0] rc_data
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] branch_count,
    output logic [31:0] taken_count
`endif
);

    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] ADVANCE = 2'd1;
    localparam logic [1:0] READ    = 2'd2;
    localparam logic [1:0] RESOLVE = 2'd3;

    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1C;
    localparam logic [5:0] OP_BNE = 6'h1D;

    localparam logic [1:0] PCSEL_NORMAL = 2'b00;
    localparam logic [1:0] PCSEL_BEQ    = 2'b01;
    localparam logic [1:0] PCSEL_JMP    = 2'b10;
    localparam logic [1:0] PCSEL_BNE    = 2'b11;

    logic [1:0]  state;
    logic [31:0] instr_q;
    logic [31:0] pc_next_q;

    logic        accept;
    logic        in_is_ctrl;
    logic [5:0]  op_q;
    logic [4:0]  rc_q;
    logic [1:0]  pcsel_q;
    logic        taken;

    // NOTE: instr_ready is gated by rst combinationally so it drops the instant reset asserts,
    // not one edge later; everything else comes straight from flops.
    assign instr_ready = (state == FETCH) && !rst;
    assign accept      = instr_valid && instr_ready;
    assign in_is_ctrl  = (instr[31:26] == OP_JMP) || (instr[31:26] == OP_BEQ) ||
                         (instr[31:26] == OP_BNE);

    assign op_q = instr_q[31:26];
    assign rc_q = instr_q[25:21];

    always_comb begin
        pcsel_q = PCSEL_JMP;
        taken   = 1'b1;
        if (op_q == OP_BEQ) begin
            pcsel_q = PCSEL_BEQ;
            taken   = (ra_data == 32'd0);
        end else if (op_q == OP_BNE) begin
            pcsel_q = PCSEL_BNE;
            taken   = (ra_data != 32'd0);
        end
    end

    // NOTE: every flop here has an async reset; nothing is memory-like, so clearing all of it
    // costs nothing and guarantees no stale pulse survives reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            instr_q   <= '0;
            pc_next_q <= '0;
            ra_addr   <= '0;
            pc_clk_en <= 1'b0;
            pcsel     <= PCSEL_NORMAL;
            offset    <= '0;
            address   <= '0;
            rc_we     <= 1'b0;
            rc_addr   <= '0;
            rc_data   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every branch below
            // reads the pre-edge values regardless of statement order.
            case (state)
                FETCH: begin
                    if (accept) begin
                        instr_q   <= instr;
                        pc_next_q <= pc_next_i;
                        if (in_is_ctrl) begin
                            ra_addr <= instr[20:16];
                            state   <= READ;
                        end else begin
                            pc_clk_en <= 1'b1;
                            pcsel     <= PCSEL_NORMAL;
                            state     <= ADVANCE;
                        end
                    end
                end
                ADVANCE: begin
                    pc_clk_en <= 1'b0;
                    state     <= FETCH;
                end
                READ: begin
                    address   <= (op_q == OP_JMP) ? {ra_data[31:2], 2'b00} : ra_data;
                    pc_clk_en <= 1'b1;
                    pcsel     <= pcsel_q;
                    offset    <= instr_q[15:0];
                    rc_addr   <= rc_q;
                    rc_data   <= pc_next_q;
                    rc_we     <= (rc_q != 5'd31);
                    state     <= RESOLVE;
                end
                default: begin
                    pc_clk_en <= 1'b0;
                    rc_we     <= 1'b0;
                    state     <= FETCH;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (state == READ) begin
            if (branch_count != 32'hFFFF_FFFF) branch_count <= branch_count + 32'd1;
            if (taken && taken_count != 32'hFFFF_FFFF) taken_count <= taken_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized self-checking bench for branch_ctrl against a transaction-level reference model.
// Outputs are sampled on the falling edge; inputs change just after the rising edge.
module tb_branch_ctrl;

    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1C;
    localparam logic [5:0] OP_BNE = 6'h1D;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc_next_i;
    logic [4:0]  ra_addr;
    logic [31:0] ra_data;
    logic        pc_clk_en;
    logic [1:0]  pcsel;
    logic [15:0] offset;
    logic [31:0] address;
    logic        rc_we;
    logic [4:0]  rc_addr;
    logic [31:0] rc_data;
`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count;
    logic [31:0] taken_count;
`endif

    always #5 clk = ~clk;

    branch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc_next_i   (pc_next_i),
        .ra_addr     (ra_addr),
        .ra_data     (ra_data),
        .pc_clk_en   (pc_clk_en),
        .pcsel       (pcsel),
        .offset      (offset),
        .address     (address),
        .rc_we       (rc_we),
        .rc_addr     (rc_addr),
        .rc_data     (rc_data)
`ifdef BRANCH_STATS_EN
        ,
        .branch_count(branch_count),
        .taken_count (taken_count)
`endif
    );

    // Register file with asynchronous read, owned by the bench.
    logic [31:0] reg_file [32];
    assign ra_data = reg_file[ra_addr];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: values the PC-facing outputs should currently hold.
    logic [1:0]  m_pcsel;
    logic [15:0] m_offset;
    logic [31:0] m_address;
    logic [4:0]  m_ra_addr;
    logic [4:0]  m_rc_addr;
    logic [31:0] m_rc_data;
    int unsigned m_branches;
    int unsigned m_taken;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pcsel = 2'b00; m_offset = '0; m_address = '0;
        m_ra_addr = '0; m_rc_addr = '0; m_rc_data = '0;
        m_branches = 0; m_taken = 0;
    endtask

    task automatic check_outputs(input string ph, input logic rdy, input logic pce, input logic we);
        check({ph, ".instr_ready"}, {31'd0, instr_ready}, {31'd0, rdy});
        check({ph, ".pc_clk_en"},   {31'd0, pc_clk_en},   {31'd0, pce});
        check({ph, ".rc_we"},       {31'd0, rc_we},       {31'd0, we});
        check({ph, ".pcsel"},       {30'd0, pcsel},       {30'd0, m_pcsel});
        check({ph, ".offset"},      {16'd0, offset},      {16'd0, m_offset});
        check({ph, ".address"},     address,              m_address);
        check({ph, ".ra_addr"},     {27'd0, ra_addr},     {27'd0, m_ra_addr});
        check({ph, ".rc_addr"},     {27'd0, rc_addr},     {27'd0, m_rc_addr});
        check({ph, ".rc_data"},     rc_data,              m_rc_data);
`ifdef BRANCH_STATS_EN
        check({ph, ".branch_count"}, branch_count, m_branches);
        check({ph, ".taken_count"},  taken_count,  m_taken);
`endif
    endtask

    // Issues one instruction starting at a falling edge with the block idle; returns at the
    // falling edge of the first cycle in which the next instruction may be presented.
    task automatic run_instr(input logic [31:0] w, input logic [31:0] pcn, input bit rst_in_resolve);
        logic [5:0]  op;
        logic [4:0]  rc, ra;
        logic [31:0] rv;
        bit          ctrl;
        op = w[31:26]; rc = w[25:21]; ra = w[20:16];
        rv = reg_file[ra];
        ctrl = (op == OP_JMP) || (op == OP_BEQ) || (op == OP_BNE);
        check("present.instr_ready", {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1; instr = w; pc_next_i = pcn;
        @(posedge clk);
        #1;
        instr_valid = 1'b0; instr = $urandom; pc_next_i = $urandom;
        @(negedge clk);
        if (!ctrl) begin
            m_pcsel = 2'b00;
            check_outputs("advance", 1'b0, 1'b1, 1'b0);
        end else begin
            m_ra_addr = ra;
            check_outputs("read", 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            m_pcsel   = (op == OP_BEQ) ? 2'b01 : (op == OP_BNE) ? 2'b11 : 2'b10;
            m_offset  = w[15:0];
            m_address = (op == OP_JMP) ? (rv & 32'hFFFF_FFFC) : rv;
            m_rc_addr = rc;
            m_rc_data = pcn;
            m_branches++;
            if (op == OP_JMP || (op == OP_BEQ && rv == 0) || (op == OP_BNE && rv != 0)) m_taken++;
            check_outputs("resolve", 1'b0, 1'b1, rc != 5'd31);
            if (rst_in_resolve) begin
                rst = 1'b1;
                #1;
                model_clear();
                check_outputs("rst_mid", 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check_outputs("post_rst", 1'b1, 1'b0, 1'b0);
                end
                return;
            end
        end
        @(negedge clk);
        check_outputs("done", 1'b1, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rc,
                                       input logic [4:0] ra, input logic [15:0] lit);
        return {op, rc, ra, lit};
    endfunction

    initial begin
        logic [5:0]  op;
        logic [4:0]  rc, ra;
        rst = 1'b1; instr_valid = 1'b0; instr = '0; pc_next_i = '0;
        for (int i = 0; i < 32; i++) reg_file[i] = $urandom;
        model_clear();

        @(negedge clk);
        check_outputs("reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs("idle", 1'b1, 1'b0, 1'b0);

        // Directed scenarios.
        run_instr(32'h8000_0000, 32'h0000_0100, 1'b0);
        reg_file[3] = 32'd0;
        run_instr(32'h70A3_FFFE, 32'h0000_0104, 1'b0);
        reg_file[2] = 32'h0000_1237;
        run_instr(32'h6C22_0000, 32'h0000_0200, 1'b0);
        reg_file[4] = 32'h0000_0055;
        run_instr(32'h77E4_0010, 32'h0000_0300, 1'b0);
        reg_file[7] = 32'd7;
        run_instr(mk(OP_BEQ, 5'd1, 5'd7, 16'h0004), 32'h400, 1'b0);
        run_instr(mk(OP_BNE, 5'd1, 5'd7, 16'h0004), 32'h404, 1'b0);
        run_instr(mk(OP_JMP, 5'd1, 5'd7, 16'h0000), 32'h408, 1'b0);

        // Reset in the middle of a control instruction.
        run_instr(mk(OP_BEQ, 5'd9, 5'd7, 16'h1234), 32'h500, 1'b1);

        // Randomized traffic with occasional idle cycles.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                instr = $urandom; pc_next_i = $urandom;
                @(negedge clk);
                check_outputs("idle_rand", 1'b1, 1'b0, 1'b0);
            end
            case ($urandom_range(0, 3))
                0: op = OP_JMP;
                1: op = OP_BEQ;
                2: op = OP_BNE;
                default: op = 6'($urandom);
            endcase
            rc = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom);
            ra = 5'($urandom);
            reg_file[ra] = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            run_instr(mk(op, rc, ra, 16'($urandom)), $urandom, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
